pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register for the 16-bit pipelined CPU. It generalises the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block with configurable payload width, valid/ready flow control, a one-entry skid buffer, synchronous flush, and halt tracking. A stall in a downstream stage no longer needs a global enable fanned out combinationally. Each stage boundary instantiates one copy.

---
 rtl/pipe_stage_skid_pkg.sv | 20 ++
 rtl/pipe_stage_skid_if.sv | 22 ++
 rtl/pipe_stage_skid_dffn.sv | 24 ++
 rtl/pipe_stage_skid.sv | 109 ++++++++++
 tb/tb_pipe_stage_skid.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared widths for the CPU inter-stage registers and the beat-width helper.
package pipe_stage_skid_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned NDATA_DEF  = 2;
  localparam int unsigned REG_W_DEF  = 4;
  localparam int unsigned CTRL_W_DEF = 2;

  // Beat layout, MSB first: hlt, wreg, dst, ctrl, data.
  function automatic int unsigned beat_width(input int unsigned data_w, input int unsigned ndata,
                                             input int unsigned reg_w, input int unsigned ctrl_w);
    return 2 + reg_w + ctrl_w + data_w * ndata;
  endfunction

  localparam int unsigned IFID_BEAT_W  = beat_width(DATA_W_DEF, 1, REG_W_DEF, CTRL_W_DEF);
  localparam int unsigned IDEX_BEAT_W  = beat_width(DATA_W_DEF, 2, REG_W_DEF, CTRL_W_DEF);
  localparam int unsigned EXMEM_BEAT_W = beat_width(DATA_W_DEF, 2, REG_W_DEF, CTRL_W_DEF);
  localparam int unsigned MEMWB_BEAT_W = beat_width(DATA_W_DEF, 2, REG_W_DEF, CTRL_W_DEF);

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat channel carrying halt, register-write, destination, control and data fields.
interface pipe_stage_skid_if
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned NDATA  = NDATA_DEF,
  parameter int unsigned REG_W  = REG_W_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF
) ();

  logic                    valid;
  logic                    ready;
  logic                    hlt;
  logic                    wreg;
  logic [REG_W-1:0]        dst;
  logic [CTRL_W-1:0]       ctrl;
  logic [NDATA*DATA_W-1:0] data;

  modport master (output valid, hlt, wreg, dst, ctrl, data, input ready);
  modport slave  (input valid, hlt, wreg, dst, ctrl, data, output ready);

endinterface

// File: rtl/pipe_stage_skid_dffn.sv
// Parametrised-width register with write enable and synchronous active-high reset.
module pipe_stage_skid_dffn #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wen,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_wen) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register: valid/ready flow control, optional one-entry skid, flush and halt
// tracking, plus a saturating count of downstream stall cycles.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned NDATA       = NDATA_DEF,
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned CTRL_W      = CTRL_W_DEF,
  parameter int unsigned SKID        = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  pipe_stage_skid_if.slave       in_if,
  pipe_stage_skid_if.master      out_if,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned BEAT_W = beat_width(DATA_W, NDATA, REG_W, CTRL_W);

  logic [BEAT_W-1:0]      w_in_beat, w_m_d, w_m_beat, w_s_beat;
  logic                   w_m_valid, w_m_valid_d, w_m_wen;
  logic                   w_s_valid, w_s_valid_d, w_s_wen;
  logic                   w_in_ready, w_acc, w_ret, w_m_hlt, w_m_wreg;
  logic                   r_halt_pend, r_halted;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_comb begin
    w_in_beat = {in_if.hlt, in_if.wreg, in_if.dst, in_if.ctrl, in_if.data};
    // Reset is gated in so the stage never advertises ready while being reset.
    if (SKID != 0) begin
      w_in_ready = !rst && !w_s_valid && !r_halt_pend && !r_halted;
    end else begin
      w_in_ready = !rst && (!w_m_valid || out_if.ready) && !r_halt_pend && !r_halted;
    end
    w_acc = in_if.valid && w_in_ready;
    w_ret = w_m_valid && out_if.ready;

    w_m_d       = w_in_beat;
    w_m_wen     = 1'b0;
    w_m_valid_d = w_m_valid;
    w_s_wen     = 1'b0;
    w_s_valid_d = w_s_valid;
    if (w_m_valid && !w_ret) begin
      w_s_wen     = w_acc && (SKID != 0);
      w_s_valid_d = w_s_valid || w_s_wen;
    end else if (w_s_valid) begin
      w_m_d       = w_s_beat;
      w_m_wen     = 1'b1;
      w_m_valid_d = 1'b1;
      w_s_valid_d = 1'b0;
    end else begin
      w_m_wen     = w_acc;
      w_m_valid_d = w_acc;
    end
    if (flush) begin
      w_m_valid_d = 1'b0;
      w_s_valid_d = 1'b0;
    end
  end

  pipe_stage_skid_dffn #(.WIDTH(1)) u_m_valid (
    .clk(clk), .rst(rst), .i_wen(1'b1), .i_d(w_m_valid_d), .o_q(w_m_valid)
  );
  pipe_stage_skid_dffn #(.WIDTH(BEAT_W)) u_m_beat (
    .clk(clk), .rst(rst), .i_wen(w_m_wen), .i_d(w_m_d), .o_q(w_m_beat)
  );
  pipe_stage_skid_dffn #(.WIDTH(1)) u_s_valid (
    .clk(clk), .rst(rst), .i_wen(1'b1), .i_d(w_s_valid_d), .o_q(w_s_valid)
  );
  pipe_stage_skid_dffn #(.WIDTH(BEAT_W)) u_s_beat (
    .clk(clk), .rst(rst), .i_wen(w_s_wen), .i_d(w_in_beat), .o_q(w_s_beat)
  );

  // A retire coinciding with flush still happened downstream, so it may still set halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_halt_pend <= 1'b0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (flush) begin
        r_halt_pend <= 1'b0;
      end else if (w_acc && in_if.hlt) begin
        r_halt_pend <= 1'b1;
      end
      if (w_ret && w_m_beat[BEAT_W-1]) begin
        r_halted <= 1'b1;
      end
      if (w_m_valid && !out_if.ready && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  always_comb begin
    {w_m_hlt, w_m_wreg, out_if.dst, out_if.ctrl, out_if.data} = w_m_beat;
    out_if.valid = w_m_valid;
    out_if.hlt   = w_m_hlt && w_m_valid;
    out_if.wreg  = w_m_wreg && w_m_valid;
    in_if.ready  = w_in_ready;
    halted       = r_halted;
    stall_cnt    = r_stall_cnt;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench: a SKID=1 (4-bit stall counter) and a SKID=0 stage share stimulus; each is checked
// every cycle against a queue model, with directed literal checks pinning the model.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        d_rst, d_flush, d_valid, d_hlt, d_wreg, d_ordy;
  logic [3:0]  d_dst;
  logic [1:0]  d_ctrl;
  logic [31:0] d_data;

  pipe_stage_skid_if #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2)) in_a ();
  pipe_stage_skid_if #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2)) out_a ();
  pipe_stage_skid_if #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2)) in_b ();
  pipe_stage_skid_if #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2)) out_b ();

  assign in_a.valid = d_valid;  assign in_b.valid = d_valid;
  assign in_a.hlt   = d_hlt;    assign in_b.hlt   = d_hlt;
  assign in_a.wreg  = d_wreg;   assign in_b.wreg  = d_wreg;
  assign in_a.dst   = d_dst;    assign in_b.dst   = d_dst;
  assign in_a.ctrl  = d_ctrl;   assign in_b.ctrl  = d_ctrl;
  assign in_a.data  = d_data;   assign in_b.data  = d_data;
  assign out_a.ready = d_ordy;  assign out_b.ready = d_ordy;

  logic        halted_a, halted_b;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  pipe_stage_skid #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2), .SKID(1),
                    .STALL_CNT_W(4)) u_skid (
    .clk(clk), .rst(d_rst), .flush(d_flush), .in_if(in_a), .out_if(out_a),
    .halted(halted_a), .stall_cnt(stall_a)
  );
  pipe_stage_skid #(.DATA_W(16), .NDATA(2), .REG_W(4), .CTRL_W(2), .SKID(0),
                    .STALL_CNT_W(16)) u_reg (
    .clk(clk), .rst(d_rst), .flush(d_flush), .in_if(in_b), .out_if(out_b),
    .halted(halted_b), .stall_cnt(stall_b)
  );

  logic        a_rdy[2], a_valid[2], a_hlt[2], a_wreg[2], a_halted[2];
  logic [3:0]  a_dst[2];
  logic [1:0]  a_ctrl[2];
  logic [31:0] a_data[2];
  logic [15:0] a_stall[2];
  always_comb begin
    a_rdy[0] = in_a.ready;      a_rdy[1] = in_b.ready;
    a_valid[0] = out_a.valid;   a_valid[1] = out_b.valid;
    a_hlt[0] = out_a.hlt;       a_hlt[1] = out_b.hlt;
    a_wreg[0] = out_a.wreg;     a_wreg[1] = out_b.wreg;
    a_dst[0] = out_a.dst;       a_dst[1] = out_b.dst;
    a_ctrl[0] = out_a.ctrl;     a_ctrl[1] = out_b.ctrl;
    a_data[0] = out_a.data;     a_data[1] = out_b.data;
    a_halted[0] = halted_a;     a_halted[1] = halted_b;
    a_stall[0] = {12'h000, stall_a};
    a_stall[1] = stall_b;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: each stage is a FIFO of beats {hlt,wreg,dst,ctrl,data}; capacity 2 (skid) or 1.
  logic [39:0] mq[2][2];
  int          mcnt[2]  = '{0, 0};
  bit          mhp[2]   = '{0, 0};
  bit          mhalt[2] = '{0, 0};
  int          mstall[2] = '{0, 0};
  int          smax[2]  = '{15, 65535};
  bit          er, ev, acc, ret;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (k == 0) er = (mcnt[k] < 2);
      else        er = (mcnt[k] == 0) || d_ordy;
      er = er && !mhp[k] && !mhalt[k] && !d_rst;
      ev = (mcnt[k] > 0);
      chk("in_ready", k, 64'(a_rdy[k]), 64'(er));
      chk("out_valid", k, 64'(a_valid[k]), 64'(ev));
      chk("out_hlt", k, 64'(a_hlt[k]), 64'(ev && mq[k][0][39]));
      chk("out_wreg", k, 64'(a_wreg[k]), 64'(ev && mq[k][0][38]));
      if (ev) begin
        chk("out_dst", k, 64'(a_dst[k]), 64'(mq[k][0][37:34]));
        chk("out_ctrl", k, 64'(a_ctrl[k]), 64'(mq[k][0][33:32]));
        chk("out_data", k, 64'(a_data[k]), 64'(mq[k][0][31:0]));
      end
      chk("halted", k, 64'(a_halted[k]), 64'(mhalt[k]));
      chk("stall_cnt", k, 64'(a_stall[k]), 64'(mstall[k]));
      if (d_rst) begin
        mcnt[k] = 0; mhp[k] = 0; mhalt[k] = 0; mstall[k] = 0;
      end else begin
        acc = d_valid && er;
        ret = ev && d_ordy;
        if (ev && !d_ordy && mstall[k] < smax[k]) mstall[k]++;
        if (ret) begin
          if (mq[k][0][39]) mhalt[k] = 1;
          mq[k][0] = mq[k][1];
          mcnt[k]--;
        end
        if (d_flush) begin
          mcnt[k] = 0; mhp[k] = 0;
        end else if (acc) begin
          mq[k][mcnt[k]] = {d_hlt, d_wreg, d_dst, d_ctrl, d_data};
          mcnt[k]++;
          if (d_hlt) mhp[k] = 1;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_flush = 0; d_hlt = 0; d_wreg = 0;
  endtask

  initial begin
    d_rst = 1; idle(); d_ordy = 0; d_dst = 0; d_ctrl = 0; d_data = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("rst_in_ready", k, 64'(a_rdy[k]), 64'd0);
    cyc(); cyc(); d_rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("post_rst_in_ready", k, 64'(a_rdy[k]), 64'd1);
      chk("post_rst_valid", k, 64'(a_valid[k]), 64'd0);
      chk("post_rst_data", k, 64'(a_data[k]), 64'd0);
      chk("post_rst_dst", k, 64'(a_dst[k]), 64'd0);
      chk("post_rst_stall", k, 64'(a_stall[k]), 64'd0);
    end

    // Streaming: one beat per cycle, one-cycle latency.
    for (int i = 1; i <= 8; i++) begin
      cyc(); d_valid = 1; d_ordy = 1; d_wreg = 1; d_dst = 4'(i);
      d_data = {16'(16'h1000 + i), 16'(i)};
      @(negedge clk);
      if (i > 1) for (int k = 0; k < 2; k++) begin
        chk("stream_valid", k, 64'(a_valid[k]), 64'd1);
        chk("stream_data", k, 64'(a_data[k]), 64'({16'(16'h1000 + i - 1), 16'(i - 1)}));
      end
    end
    cyc(); idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("stream_last", k, 64'(a_data[k]), 64'h1008_0008);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("stream_drained", k, 64'(a_valid[k]), 64'd0);
      chk("stream_stall", k, 64'(a_stall[k]), 64'd0);
    end

    // Backpressure on the skid stage: M then S fill, nothing else accepted.
    cyc(); d_ordy = 0; d_valid = 1; d_data = 32'hA1;
    @(negedge clk); chk("bp_rdy0", 0, 64'(a_rdy[0]), 64'd1);
    cyc(); d_data = 32'hA2;
    @(negedge clk); chk("bp_rdy1", 0, 64'(a_rdy[0]), 64'd1);
    chk("bp_m", 0, 64'(a_data[0]), 64'hA1);
    cyc(); d_data = 32'hA3;
    @(negedge clk); chk("bp_rdy_full", 0, 64'(a_rdy[0]), 64'd0);
    cyc(); idle();
    cyc(); d_ordy = 1;
    @(negedge clk); chk("bp_stall", 0, 64'(a_stall[0]), 64'd3);
    chk("bp_out1", 0, 64'(a_data[0]), 64'hA1);
    cyc();
    @(negedge clk); chk("bp_out2", 0, 64'(a_data[0]), 64'hA2);
    chk("bp_out2_valid", 0, 64'(a_valid[0]), 64'd1);
    cyc();
    @(negedge clk); chk("bp_empty", 0, 64'(a_valid[0]), 64'd0);

    // Flush with both entries full, then flush of a same-cycle accept.
    cyc(); d_ordy = 0; d_valid = 1; d_wreg = 1; d_data = 32'hB1;
    cyc(); d_data = 32'hB2;
    cyc(); d_data = 32'hB3; d_flush = 1;
    @(negedge clk); chk("fl_full_rdy", 0, 64'(a_rdy[0]), 64'd0);
    cyc(); idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("fl_valid", k, 64'(a_valid[k]), 64'd0);
      chk("fl_wreg", k, 64'(a_wreg[k]), 64'd0);
    end
    cyc(); d_valid = 1; d_flush = 1; d_ordy = 1; d_wreg = 1; d_data = 32'hC1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("fl_acc_rdy", k, 64'(a_rdy[k]), 64'd1);
    cyc(); idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("fl_acc_dropped", k, 64'(a_valid[k]), 64'd0);

    // Halt flushed before retiring leaves halted clear.
    cyc(); d_ordy = 0; d_valid = 1; d_hlt = 1; d_dst = 4'hF; d_data = 32'hD1;
    cyc(); idle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("hp_rdy", k, 64'(a_rdy[k]), 64'd0);
      chk("hp_out_hlt", k, 64'(a_hlt[k]), 64'd1);
      chk("hp_out_dst", k, 64'(a_dst[k]), 64'hF);
    end
    cyc(); d_flush = 1;
    cyc(); d_flush = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("hp_fl_rdy", k, 64'(a_rdy[k]), 64'd1);
      chk("hp_fl_halted", k, 64'(a_halted[k]), 64'd0);
    end

    // Halt that retires.
    cyc(); d_valid = 1; d_hlt = 1; d_dst = 4'hF; d_data = 32'hE1;
    cyc(); idle();
    cyc(); d_ordy = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("h_pre_ret", k, 64'(a_halted[k]), 64'd0);
    cyc();
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("h_halted", k, 64'(a_halted[k]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(); d_valid = 1; d_data = 32'(i);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("h_sticky", k, 64'(a_halted[k]), 64'd1);
        chk("h_blocked", k, 64'(a_rdy[k]), 64'd0);
      end
    end
    cyc(); idle(); d_rst = 1;
    cyc(); d_rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("h_rst_clear", k, 64'(a_halted[k]), 64'd0);

    // out_ready toggling: the registered stage mirrors out_ready whenever it is full.
    for (int i = 0; i < 16; i++) begin
      cyc(); d_valid = 1; d_data = 32'(32'h100 + i); d_ordy = 1'(i % 2);
      @(negedge clk);
      if (a_valid[1]) chk("tog_rdy", 1, 64'(a_rdy[1]), 64'(d_ordy));
    end
    cyc(); idle(); d_ordy = 1;
    cyc(); cyc(); cyc();

    // Saturation, then reset in the middle of a stall.
    cyc(); d_ordy = 0; d_valid = 1; d_data = 32'hF1;
    cyc(); idle();
    repeat (20) cyc();
    @(negedge clk); chk("sat_stall", 0, 64'(a_stall[0]), 64'hF);
    cyc(); d_rst = 1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("midrst_rdy", k, 64'(a_rdy[k]), 64'd0);
    cyc(); d_rst = 0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("midrst_valid", k, 64'(a_valid[k]), 64'd0);
      chk("midrst_data", k, 64'(a_data[k]), 64'd0);
      chk("midrst_dst", k, 64'(a_dst[k]), 64'd0);
      chk("midrst_ctrl", k, 64'(a_ctrl[k]), 64'd0);
      chk("midrst_stall", k, 64'(a_stall[k]), 64'd0);
    end

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      d_rst   = ($urandom_range(0, 299) == 0);
      d_flush = ($urandom_range(0, 31) == 0);
      d_valid = ($urandom_range(0, 9) < 7);
      d_hlt   = ($urandom_range(0, 255) == 0);
      d_wreg  = 1'($urandom);
      d_dst   = 4'($urandom);
      d_ctrl  = 2'($urandom);
      d_data  = $urandom;
      d_ordy  = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
    end
    cyc(); idle(); d_rst = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
